iir_deemph: RTL and testbench
=============================

# iir_deemph

- Single-pole de-emphasis IIR stage of the FM audio path, directly upstream of the gain stage.
- Pops quantized audio samples from a first-word-fall-through input FIFO and runs the two-tap IIR with one shared MAC per tap.
- Pushes each filtered sample into the FIFO that feeds the gain stage.
- Fixed-point, quantized with `BITS` fractional bits; results match the C reference model bit-exactly.

## Interface

**Parameters**
- `DATA_WIDTH`, 32: sample and coefficient width, signed two's complement.
- `TAPS`, 2: IIR taps.
- `BITS`, 10: quantization fractional bits (`QUANT_VAL` = 1024).

**Ports**
- `clock`, in, 1: single clock for the whole block.
- `reset`, in, 1: synchronous, active-high.
- `din`, in, `DATA_WIDTH`: input FIFO head; valid whenever `in_empty` = 0.
- `in_empty`, in, 1: input FIFO empty.
- `in_rd_en`, out, 1: pop input FIFO this cycle.
- `dout`, out, `DATA_WIDTH`: filtered sample to the output FIFO.
- `out_full`, in, 1: output FIFO full.
- `out_wr_en`, out, 1: push `dout` this cycle.

## Operation

**Coefficients** (from package)
- `IIR_X_COEFFS` = {178, 178}.
- `IIR_Y_COEFFS` = {0, -666}.

**Filter equation**
- y[n] = dq(X0·x[n]) + dq(X1·x[n-1]) + dq(Y0·0) + dq(Y1·y[n-1]).
- Each product is dequantized individually, then summed.

**Arithmetic**
- Products: `DATA_WIDTH`×`DATA_WIDTH`, truncated to the low `DATA_WIDTH` bits (C int wrap).
- dq(p): signed divide by 2^BITS, rounding toward zero. Negative p gets (2^BITS − 1) added before the arithmetic shift. A plain arithmetic shift is not acceptable.
- Accumulator: `DATA_WIDTH` bits, wraps modulo 2^DATA_WIDTH, no saturation.

**History**
- `x_hist[0..TAPS-1]`: x_hist[0] = newest input.
- `y_hist[1..TAPS-1]`: y_hist[1] = previous output.
- Both arrays are zero after reset.

**FSM: `S_IN` → `S_MAC` → `S_OUT` → `S_IN`**
- `S_IN`: `in_rd_en` = ~`in_empty`. On a pop, shift `x_hist` (x_hist[0] ← `din`), clear the accumulator and tap counter, go to `S_MAC`. Otherwise stay.
- `S_MAC`: one tap per cycle, i = 0..TAPS-1: acc += dq(X[i]·x_hist[i]) + dq(Y[i]·y_hist[i]), with the feedback term fixed to 0 for i = 0. After tap TAPS-1, `dout` ← final sum, go to `S_OUT`. Ignores `in_empty` and `out_full`.
- `S_OUT`: `out_wr_en` = ~`out_full`. On a push, shift `y_hist` (y_hist[1] ← `dout`) and go to `S_IN`. Otherwise hold, with `dout` stable.

**Boundary conditions**
- Input empty: idle in `S_IN`; no state or history change.
- Output full: stall in `S_OUT` indefinitely; no pop occurs while stalled.
- Reset mid-operation: the in-flight sample is discarded and histories are cleared; no partial write ever occurs.
- Overflow: wraps silently.

## Timing

**Reset values**
- State `S_IN`; `dout` = 0; histories, accumulator and counter = 0.
- `in_rd_en` = 0 and `out_wr_en` = 0, forced while `reset` is high.

**Output types**
- `in_rd_en`, `out_wr_en`: combinational from state and FIFO flags.
- `dout`: registered.

**Latency and throughput**
- Pop at cycle k → earliest push at cycle k+TAPS+1 (k+3 for the default).
- Unstalled throughput: one sample per TAPS+2 cycles (4).
- Never more than one sample in flight; `in_rd_en` and `out_wr_en` are never high in the same cycle.

## Structure

**Shared package `fm_radio_pkg`**
- `DATA_WIDTH`, `BITS`, `QUANT_VAL`, `IIR_TAPS`.
- `IIR_X_COEFFS` and `IIR_Y_COEFFS` as typed constant arrays.
- `dequantize` function (toward-zero shift), reused by other FIR/IIR stages.
- FSM state enum stays local to the block.

**Sub-modules**
- None. Single module; the MAC is inline.
- A `iir_deemph_top` wrapper (input FIFO + `iir_deemph` + output FIFO) is added for the bench, mirroring other stage tops.

## Test plan

- **Impulse:** x = 1024 then zeros → outputs 178, 63, −40, 26 (y = dq(−666·prev) onward); matches the C model.
- **Toward-zero rounding:** single x = −1 from reset → y = 0, not −1. Then x = −2048 → y = −356.
- **Throughput:** 8 samples preloaded, `out_full` = 0 → `out_wr_en` pulses exactly every 4 cycles; first pulse 3 cycles after first `in_rd_en`.
- **Backpressure:** `out_full` high for 10 cycles while in `S_OUT` → `out_wr_en` = 0 and `in_rd_en` = 0 throughout, `dout` constant. The single push happens on the first cycle `out_full` = 0.
- **Starvation:** `in_empty` high for 20 cycles mid-stream → no strobes; the next output is still correct using the retained history.
- **Reset mid-`S_MAC`:** assert `reset` 1 cycle → no push. The next impulse of 1024 gives 178, 63 (history cleared).

Source files
------------

// File: rtl/fm_radio_pkg.sv
// Shared FM radio datapath constants: sample width, quantization, IIR
// de-emphasis coefficients and the toward-zero dequantize helper used by
// the FIR/IIR stages.
package fm_radio_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BITS       = 10;
  localparam int unsigned QUANT_VAL  = 1 << BITS;
  localparam int unsigned IIR_TAPS   = 2;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  localparam sample_t IIR_X_COEFFS [IIR_TAPS] = '{sample_t'(178), sample_t'(178)};
  localparam sample_t IIR_Y_COEFFS [IIR_TAPS] = '{sample_t'(0), sample_t'(-666)};

  // Signed divide by 2^bits rounding toward zero: negative values are biased
  // by (2^bits - 1) before the arithmetic shift so they do not round down.
  function automatic sample_t dequantize(input sample_t p, input int unsigned bits);
    sample_t bias;
    sample_t biased;
    bias   = sample_t'((sample_t'(1) <<< bits) - sample_t'(1));
    biased = p[DATA_WIDTH-1] ? sample_t'(p + bias) : p;
    return biased >>> bits;
  endfunction

endpackage

// File: rtl/iir_deemph_if.sv
// FIFO-side bus of the de-emphasis stage.
//   din/in_empty/in_rd_en    : first-word-fall-through input FIFO head and pop
//   dout/out_full/out_wr_en  : output FIFO data, full flag and push
// slave = filter side, master = FIFO/environment side.
interface iir_deemph_if #(
  parameter int unsigned DATA_WIDTH = fm_radio_pkg::DATA_WIDTH
);
  logic signed [DATA_WIDTH-1:0] din;
  logic                         in_empty;
  logic                         in_rd_en;
  logic signed [DATA_WIDTH-1:0] dout;
  logic                         out_full;
  logic                         out_wr_en;

  modport master (
    output din, in_empty, out_full,
    input  in_rd_en, dout, out_wr_en
  );

  modport slave (
    input  din, in_empty, out_full,
    output in_rd_en, dout, out_wr_en
  );
endinterface

// File: rtl/iir_deemph.sv
// Single-pole de-emphasis IIR stage. Pops one sample from the input FIFO,
// accumulates one tap per cycle through a shared MAC, then pushes the result
// to the output FIFO. At most one sample is in flight.
// Ports:
//   clock     : block clock
//   reset     : synchronous, active-high; clears state, histories and dout
//   bus.din/in_empty/in_rd_en   : input FIFO (in_rd_en combinational)
//   bus.dout/out_full/out_wr_en : output FIFO (dout registered, out_wr_en comb)
module iir_deemph #(
  parameter int unsigned DATA_WIDTH = fm_radio_pkg::DATA_WIDTH,
  parameter int unsigned TAPS       = fm_radio_pkg::IIR_TAPS,
  parameter int unsigned BITS       = fm_radio_pkg::BITS
) (
  input logic         clock,
  input logic         reset,
  iir_deemph_if.slave bus
);
  import fm_radio_pkg::*;

  localparam int unsigned CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  typedef enum logic [1:0] {S_IN, S_MAC, S_OUT} state_t;

  state_t state;
  state_t state_next;

  logic signed [DATA_WIDTH-1:0] x_hist [TAPS];
  logic signed [DATA_WIDTH-1:0] y_hist [TAPS];  // index 0 unused, held at zero
  logic signed [DATA_WIDTH-1:0] acc;
  logic signed [DATA_WIDTH-1:0] x_prod;
  logic signed [DATA_WIDTH-1:0] y_prod;
  logic signed [DATA_WIDTH-1:0] tap_sum;
  logic [CNT_W-1:0]             tap;
  logic                         last_tap;

  assign last_tap = (tap == LAST_TAP);

  // Shared MAC: products wrap to DATA_WIDTH, each dequantized before summing.
  always_comb begin
    x_prod  = DATA_WIDTH'(IIR_X_COEFFS[tap] * x_hist[tap]);
    y_prod  = DATA_WIDTH'(IIR_Y_COEFFS[tap] * y_hist[tap]);
    tap_sum = dequantize(x_prod, BITS);
    // Feedback contributes nothing on tap 0.
    if (tap != '0) begin
      tap_sum = tap_sum + dequantize(y_prod, BITS);
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IN:    if (!bus.in_empty) state_next = S_MAC;
      S_MAC:   if (last_tap)      state_next = S_OUT;
      S_OUT:   if (!bus.out_full) state_next = S_IN;
      default: state_next = S_IN;
    endcase
  end

  // FIFO strobes; forced low during reset so no pop/push leaks out.
  always_comb begin
    bus.in_rd_en  = 1'b0;
    bus.out_wr_en = 1'b0;
    if (!reset) begin
      case (state)
        S_IN:    bus.in_rd_en  = !bus.in_empty;
        S_OUT:   bus.out_wr_en = !bus.out_full;
        default: ;
      endcase
    end
  end

  // Datapath: histories, accumulator, tap counter and output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        x_hist[i] <= '0;
        y_hist[i] <= '0;
      end
      acc      <= '0;
      tap      <= '0;
      bus.dout <= '0;
    end else begin
      case (state)
        S_IN: begin
          if (bus.in_rd_en) begin
            x_hist[0] <= bus.din;
            for (int i = 1; i < TAPS; i++) begin
              x_hist[i] <= x_hist[i-1];
            end
            acc <= '0;
            tap <= '0;
          end
        end
        S_MAC: begin
          if (last_tap) begin
            bus.dout <= acc + tap_sum;
          end else begin
            acc <= acc + tap_sum;
            tap <= tap + CNT_W'(1);
          end
        end
        S_OUT: begin
          if (bus.out_wr_en) begin
            y_hist[1] <= bus.dout;
            for (int i = 2; i < TAPS; i++) begin
              y_hist[i] <= y_hist[i-1];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_deemph.sv
// Directed bench for iir_deemph: behavioural FIFOs on both sides, an
// independent C-style reference model feeding a scoreboard queue.
module tb_iir_deemph;

  localparam int unsigned DW = 32;

  logic clock = 1'b0;
  logic reset;

  iir_deemph_if #(.DATA_WIDTH(DW)) bus ();

  iir_deemph #(.DATA_WIDTH(DW), .TAPS(2), .BITS(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  int in_q[$];
  int exp_q[$];
  int out_log[$];
  int rd_cyc[$];
  int wr_cyc[$];

  logic full_ctl;
  int   xh1;
  int   yh1;
  logic rd_seen;
  logic wr_seen;
  int   dout_seen;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // C integer division truncates toward zero.
  function automatic int dq(input int p);
    return p / 1024;
  endfunction

  task automatic push_sample(input int x);
    int y;
    y   = dq(178 * x) + dq(178 * xh1) + dq(-666 * yh1);
    xh1 = x;
    yh1 = y;
    in_q.push_back(x);
    exp_q.push_back(y);
  endtask

  task automatic model_reset();
    xh1 = 0;
    yh1 = 0;
    exp_q.delete();
  endtask

  // One clock: present FIFO flags at negedge, sample strobes, score, advance.
  task automatic tick();
    @(negedge clock);
    bus.in_empty = (in_q.size() == 0);
    bus.din      = (in_q.size() == 0) ? '0 : in_q[0];
    bus.out_full = full_ctl;
    #1;
    rd_seen   = bus.in_rd_en;
    wr_seen   = bus.out_wr_en;
    dout_seen = bus.dout;
    check("rd_wr_overlap", int'(rd_seen & wr_seen), 0);
    if (wr_seen) begin
      check("write_while_full", int'(full_ctl), 0);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed dout %0d expected no write", dout_seen);
      end
      if (exp_q.size() != 0) begin
        check("dout", dout_seen, exp_q.pop_front());
      end
      out_log.push_back(dout_seen);
      wr_cyc.push_back(cycle);
    end
    if (rd_seen) begin
      checks++;
      assert (in_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pop: observed pop expected none");
      end
      if (in_q.size() != 0) void'(in_q.pop_front());
      rd_cyc.push_back(cycle);
    end
    @(posedge clock);
    #1;
    cycle++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", int'(in_q.size() + exp_q.size()), 0);
  endtask

  task automatic wait_pop(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!rd_seen && n < budget);
    check("pop_seen", int'(rd_seen), 1);
  endtask

  initial begin
    int want_imp[4];
    int held;
    int strobes;

    reset        = 1'b1;
    full_ctl     = 1'b0;
    bus.din      = '0;
    bus.in_empty = 1'b1;
    bus.out_full = 1'b0;
    xh1          = 0;
    yh1          = 0;

    // Reset: strobes forced low even with data waiting.
    in_q.push_back(555);
    tick();
    repeat (2) begin
      tick();
      check("reset_rd", int'(rd_seen), 0);
      check("reset_wr", int'(wr_seen), 0);
      check("reset_dout", dout_seen, 0);
    end
    in_q.delete();
    reset = 1'b0;
    tick();

    // Impulse response.
    out_log.delete();
    push_sample(1024);
    repeat (3) push_sample(0);
    drain(100);
    want_imp = '{178, 63, -40, 26};
    check("impulse_count", out_log.size(), 4);
    for (int i = 0; i < 4; i++) check("impulse_val", out_log[i], want_imp[i]);

    // Toward-zero rounding from a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    out_log.delete();
    push_sample(-1);
    push_sample(-2048);
    drain(50);
    check("round_neg1", out_log[0], 0);
    check("round_neg2048", out_log[1], -356);

    // Throughput with 8 preloaded samples, including wrapping values.
    out_log.delete();
    rd_cyc.delete();
    wr_cyc.delete();
    push_sample(1000);
    push_sample(-3000);
    push_sample(123456);
    push_sample(-7);
    push_sample(2000000000);
    push_sample(-2000000000);
    push_sample(5);
    push_sample(0);
    drain(100);
    check("tp_count", wr_cyc.size(), 8);
    check("tp_latency", wr_cyc[0] - rd_cyc[0], 3);
    for (int i = 1; i < 8; i++) check("tp_period", wr_cyc[i] - wr_cyc[i-1], 4);

    // Backpressure: stall in S_OUT with another sample waiting.
    push_sample(300);
    push_sample(400);
    full_ctl = 1'b1;
    wait_pop(10);
    tick();
    tick();
    held = exp_q[0];
    repeat (10) begin
      tick();
      check("bp_wr", int'(wr_seen), 0);
      check("bp_rd", int'(rd_seen), 0);
      check("bp_dout", dout_seen, held);
    end
    full_ctl = 1'b0;
    tick();
    check("bp_release_wr", int'(wr_seen), 1);
    drain(50);

    // Starvation: no strobes while empty, history retained afterwards.
    strobes = 0;
    repeat (20) begin
      tick();
      strobes += int'(rd_seen) + int'(wr_seen);
    end
    check("starve_strobes", strobes, 0);
    push_sample(777);
    push_sample(-5000);
    drain(50);

    // Reset in the middle of the MAC: in-flight sample dropped.
    push_sample(1024);
    wait_pop(10);
    reset = 1'b1;
    tick();
    check("midrst_rd", int'(rd_seen), 0);
    check("midrst_wr", int'(wr_seen), 0);
    reset = 1'b0;
    model_reset();
    out_log.delete();
    repeat (6) tick();
    check("midrst_no_push", out_log.size(), 0);
    push_sample(1024);
    push_sample(0);
    drain(50);
    check("midrst_count", out_log.size(), 2);
    check("midrst_y0", out_log[0], 178);
    check("midrst_y1", out_log[1], 63);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
